// File: rtl/sw_tx_sched_if.sv
// sw_tx_sched_if: request/dv inputs and grant/select/status outputs of the tx scheduler
interface sw_tx_sched_if;
  logic       I_en;
  logic [3:0] I_req;
  logic       I_sel_dv;
  logic [3:0] O_gnt;
  logic [1:0] O_sel;
  logic       O_sel_vld;
  logic       O_force_err;
  logic       O_timeout;
  logic       O_trunc;
  modport master (
    input  I_en, I_req, I_sel_dv,
    output O_gnt, O_sel, O_sel_vld, O_force_err, O_timeout, O_trunc
  );
  modport slave (
    output I_en, I_req, I_sel_dv,
    input  O_gnt, O_sel, O_sel_vld, O_force_err, O_timeout, O_trunc
  );
endinterface

// File: rtl/sw_tx_sched.sv
// sw_tx_sched: frame-level round-robin owner of the shared GMII tx path with IFG, grant timeout and truncation
module sw_tx_sched #(
  parameter int IFG         = 12,
  parameter int MAX_LEN     = 1530,
  parameter int GNT_TIMEOUT = 16
) (
  input logic I_125m_clk,
  input logic I_rst,
  sw_tx_sched_if.master bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int WW = $clog2(GNT_TIMEOUT + 1);
  localparam int IW = $clog2(IFG + 1);
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_XFER, S_DRAIN, S_IFG} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel, sel_n, pick;
  logic [3:0] gnt, gnt_n;
  logic vld, vld_n, ferr, ferr_n, tout, tout_n, trunc, trunc_n;
  logic [LW-1:0] len, len_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [IW-1:0] icnt, icnt_n;
  // descending scan so the port closest to ptr wins
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--)
      if (bus.I_req[ptr + 2'(i)]) pick = ptr + 2'(i);
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    vld_n   = vld;
    ferr_n  = 1'b0;
    tout_n  = 1'b0;
    trunc_n = 1'b0;
    len_n   = len;
    wcnt_n  = wcnt;
    icnt_n  = icnt;
    case (state)
      S_IDLE: if (bus.I_en && |bus.I_req) begin
        state_n = S_GRANT;
        gnt_n   = 4'b0001 << pick;
        sel_n   = pick;
        vld_n   = 1'b1;
        wcnt_n  = '0;
      end
      S_GRANT: if (bus.I_sel_dv) begin
        state_n = S_XFER;
        len_n   = LW'(1);
      end else if (wcnt == WW'(GNT_TIMEOUT - 1)) begin
        state_n = S_IDLE;
        gnt_n   = '0;
        vld_n   = 1'b0;
        tout_n  = 1'b1;
        ptr_n   = sel + 2'd1;
      end else wcnt_n = wcnt + 1'b1;
      S_XFER: if (!bus.I_sel_dv) begin
        state_n = S_IFG;
        gnt_n   = '0;
        vld_n   = 1'b0;
        ptr_n   = sel + 2'd1;
        icnt_n  = IW'(1);
      end else if (len == LW'(MAX_LEN - 1)) begin
        state_n = S_DRAIN;
        gnt_n   = '0;
        vld_n   = 1'b0;
        ferr_n  = 1'b1;
        trunc_n = 1'b1;
        len_n   = LW'(MAX_LEN);
      end else len_n = len + 1'b1;
      S_DRAIN: if (!bus.I_sel_dv) begin
        state_n = S_IFG;
        ptr_n   = sel + 2'd1;
        icnt_n  = IW'(1);
      end
      S_IFG: begin
        icnt_n  = icnt + 1'b1;
        state_n = (icnt >= IW'(IFG - 1)) ? S_IDLE : S_IFG;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge I_125m_clk) begin
    if (I_rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      vld   <= 1'b0;
      ferr  <= 1'b0;
      tout  <= 1'b0;
      trunc <= 1'b0;
      len   <= '0;
      wcnt  <= '0;
      icnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      vld   <= vld_n;
      ferr  <= ferr_n;
      tout  <= tout_n;
      trunc <= trunc_n;
      len   <= len_n;
      wcnt  <= wcnt_n;
      icnt  <= icnt_n;
    end
  end
  assign bus.O_gnt       = gnt;
  assign bus.O_sel       = sel;
  assign bus.O_sel_vld   = vld;
  assign bus.O_force_err = ferr;
  assign bus.O_timeout   = tout;
  assign bus.O_trunc     = trunc;
endmodule

// File: tb/tb_sw_tx_sched.sv
// tb_sw_tx_sched: scoreboard of expected grants (port and cycle) plus direct checks of pulses and boundaries
module tb_sw_tx_sched;
  localparam int ML = 1530;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_vld = 1'b0;
  exp_t sb[$];
  sw_tx_sched_if bus ();
  sw_tx_sched dut (.I_125m_clk(clk), .I_rst(rst), .bus(bus));
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [3:0] g, input logic [1:0] s, input int c);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    e.cyc = c;
    sb.push_back(e);
  endtask
  task automatic wait_vld(output int g);
    for (int k = 0; k < 40 && !bus.O_sel_vld; k++) tick(1);
    if (!bus.O_sel_vld) chk("grant wait", 0, 1);
    g = cyc;
  endtask
  task automatic do_reset();
    bus.I_req = '0;
    bus.I_sel_dv = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst gnt", bus.O_gnt, 0);
    chk("rst vld", bus.O_sel_vld, 0);
  endtask
  // grant monitor: every rising sel_vld must match the oldest expected grant
  always @(negedge clk) begin
    if (bus.O_sel_vld && !prev_vld) begin
      if (sb.size() == 0) chk("unexpected grant", bus.O_gnt, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb gnt", bus.O_gnt, e.gnt);
        chk("sb sel", bus.O_sel, e.sel);
        chk("sb cycle", cyc, e.cyc);
      end
    end
    if (bus.O_sel_vld) chk("vld onehot", $onehot(bus.O_gnt), 1);
    prev_vld <= bus.O_sel_vld;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int g, c0;
    bus.I_en = 1'b0;
    bus.I_req = '0;
    bus.I_sel_dv = 1'b0;
    do_reset();
    chk("rst sel", bus.O_sel, 0);
    chk("rst ferr", bus.O_force_err, 0);
    chk("rst tout", bus.O_timeout, 0);
    chk("rst trunc", bus.O_trunc, 0);
    // single frame
    bus.I_req = 4'b0001;
    bus.I_en = 1'b1;
    push(4'b0001, 2'd0, cyc + 1);
    wait_vld(g);
    tick(2);
    bus.I_sel_dv = 1'b1;
    tick(72);
    bus.I_sel_dv = 1'b0;
    c0 = cyc;
    push(4'b0001, 2'd0, c0 + 13);
    tick(1);
    @(negedge clk);
    chk("single drop gnt", bus.O_gnt, 0);
    wait_vld(g);
    do_reset();
    // round robin
    bus.I_req = 4'b1111;
    push(4'b0001, 2'd0, cyc + 1);
    for (int i = 0; i < 4; i++) begin
      wait_vld(g);
      bus.I_sel_dv = 1'b1;
      tick(64);
      bus.I_sel_dv = 1'b0;
      push(4'(1 << ((i + 1) % 4)), 2'((i + 1) % 4), cyc + 13);
      tick(1);
    end
    wait_vld(g);
    do_reset();
    // grant timeout
    bus.I_req = 4'b0100;
    push(4'b0100, 2'd2, cyc + 1);
    wait_vld(g);
    bus.I_req = 4'b0110;
    push(4'b0010, 2'd1, g + 17);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to gnt held", bus.O_gnt, 4'b0100);
      chk("to no pulse", bus.O_timeout, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("to pulse", bus.O_timeout, 1);
    chk("to gnt clr", bus.O_gnt, 0);
    tick(1);
    @(negedge clk);
    chk("to one pulse", bus.O_timeout, 0);
    wait_vld(g);
    do_reset();
    // oversize frame on port 1
    bus.I_req = 4'b0010;
    push(4'b0010, 2'd1, cyc + 1);
    wait_vld(g);
    bus.I_req = '0;
    bus.I_sel_dv = 1'b1;
    tick(ML - 1);
    @(negedge clk);
    chk("trunc early", bus.O_trunc, 0);
    chk("trunc gnt held", bus.O_gnt, 4'b0010);
    tick(1);
    @(negedge clk);
    chk("trunc pulse", bus.O_trunc, 1);
    chk("trunc ferr", bus.O_force_err, 1);
    chk("trunc gnt clr", bus.O_gnt, 0);
    chk("trunc vld clr", bus.O_sel_vld, 0);
    tick(1);
    @(negedge clk);
    chk("trunc one pulse", bus.O_trunc, 0);
    chk("ferr one pulse", bus.O_force_err, 0);
    tick(1600 - ML - 1 - 10);
    bus.I_req = 4'b0010;
    tick(10);
    bus.I_sel_dv = 1'b0;
    c0 = cyc;
    push(4'b0010, 2'd1, c0 + 13);
    tick(3);
    bus.I_sel_dv = 1'b1;
    tick(2);
    bus.I_sel_dv = 1'b0;
    wait_vld(g);
    do_reset();
    // enable dropped mid-frame
    bus.I_req = 4'b0001;
    push(4'b0001, 2'd0, cyc + 1);
    wait_vld(g);
    bus.I_sel_dv = 1'b1;
    tick(5);
    bus.I_en = 1'b0;
    tick(9);
    @(negedge clk);
    chk("en frame holds", bus.O_sel_vld, 1);
    tick(1);
    bus.I_sel_dv = 1'b0;
    tick(30);
    @(negedge clk);
    chk("en no grant", bus.O_sel_vld, 0);
    bus.I_en = 1'b1;
    push(4'b0001, 2'd0, cyc + 1);
    wait_vld(g);
    do_reset();
    // reset during a frame
    bus.I_req = 4'b0100;
    push(4'b0100, 2'd2, cyc + 1);
    wait_vld(g);
    bus.I_req = '0;
    bus.I_sel_dv = 1'b1;
    tick(10);
    rst = 1'b1;
    bus.I_req = 4'b1000;
    tick(1);
    @(negedge clk);
    chk("mid rst gnt", bus.O_gnt, 0);
    chk("mid rst sel", bus.O_sel, 0);
    chk("mid rst vld", bus.O_sel_vld, 0);
    chk("mid rst ferr", bus.O_force_err, 0);
    chk("mid rst tout", bus.O_timeout, 0);
    chk("mid rst trunc", bus.O_trunc, 0);
    rst = 1'b0;
    bus.I_sel_dv = 1'b0;
    push(4'b1000, 2'd3, cyc + 1);
    tick(1);
    wait_vld(g);
    tick(1);
    chk("sb empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
